qar_fetch_unit: RTL

//   Instruction fetch front-end upstream of the qar_core decode/execute stage.

---
 rtl/qar_pkg.sv | 17 +
 rtl/qar_fetch_fifo.sv | 87 ++++++++
 rtl/qar_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/qar_pkg.sv
// Shared types and constants for the qar fetch front-end.
package qar_pkg;

   localparam int unsigned QAR_XLEN = 32;
   localparam int unsigned QAR_ILEN = 32;
   localparam logic [QAR_XLEN-1:0] QAR_PC_STEP = 32'd4;

   typedef struct packed {
      logic [QAR_XLEN-1:0] pc;
      logic [QAR_ILEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [QAR_XLEN-1:0] qar_align(input logic [QAR_XLEN-1:0] addr);
      return {addr[QAR_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/qar_fetch_fifo.sv
// Synchronous FIFO of fetched words with a registered head entry and flush.
module qar_fetch_fifo
   import qar_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output fetch_entry_t             head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   fetch_entry_t             head_q, head_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]              count_q, count_d;
   logic                     valid_q, valid_d;
   logic                     do_push, do_pop;

   // Next-state storage; the head register is reloaded from the post-update array.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && valid_q;
      do_push  = push && ((count_q < CNT_FULL) || do_pop);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
      valid_d = (count_d != '0);
      head_d  = mem_d[rd_ptr_d];
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         head_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         head_q   <= head_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   assign count      = count_q;
   assign head_valid = valid_q;
   assign head       = head_q;

endmodule

// File: rtl/qar_fetch_unit.sv
// Instruction fetch front-end: PC sequencing, one-deep request credit, redirect and drop handling.
module qar_fetch_unit
   import qar_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          outstanding_q, outstanding_d;
   logic          drop_q, drop_d;
   logic          active_q;
   logic          rsp, outstanding_after, push, issue, fire;
   logic [CW:0]   credits;
   logic [CW-1:0] count;
   logic          head_valid;
   fetch_entry_t  head, push_data;

   // Credits count the word accepted this cycle plus any still in flight, so a granted read always finds a slot.
   always_comb begin
      rsp               = imem_rvalid && outstanding_q;
      outstanding_after = outstanding_q && !imem_rvalid;
      push              = rsp && !drop_q && !redirect_valid;
      credits           = {1'b0, count} + (CW+1)'(push) + (CW+1)'(outstanding_after);
      issue             = active_q && !redirect_valid && (!outstanding_q || imem_rvalid) &&
                          (credits < CREDIT_LIMIT);
      fire              = issue && imem_gnt;
      push_data.pc      = req_pc_q;
      push_data.inst    = imem_rdata;
      if (redirect_valid) begin
         fetch_pc_d = qar_align(redirect_pc);
      end else if (fire) begin
         fetch_pc_d = fetch_pc_q + QAR_PC_STEP;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
      if (fire) begin
         req_pc_d = fetch_pc_q;
      end else begin
         req_pc_d = req_pc_q;
      end
      outstanding_d = outstanding_after || fire;
      if (redirect_valid) begin
         drop_d = outstanding_after;
      end else if (rsp) begin
         drop_d = 1'b0;
      end else begin
         drop_d = drop_q;
      end
   end

   // Fetch control registers; active_q keeps the request low until reset has been released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= 32'h0000_0000;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         active_q      <= 1'b1;
      end
   end

   qar_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_data),
      .pop        (inst_ready),
      .flush      (redirect_valid),
      .count      (count),
      .head_valid (head_valid),
      .head       (head)
   );

   assign imem_req   = issue;
   assign imem_addr  = fetch_pc_q;
   assign inst_valid = head_valid;
   assign inst_data  = head.inst;
   assign inst_pc    = head.pc;

endmodule
